// File: rtl/core_debug_arbiter.sv
// Two-host round-robin arbiter for the core debug command channel.
// One command outstanding; owner gets the response or a timeout error.
module core_debug_arbiter #(
    parameter int unsigned P_TIMEOUT = 1024
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iA_CMD_REQ,
    output logic        oA_CMD_BUSY,
    input  logic [3:0]  iA_CMD_COMMAND,
    input  logic [7:0]  iA_CMD_TARGET,
    input  logic [31:0] iA_CMD_DATA,
    output logic        oA_RESP_VALID,
    output logic        oA_RESP_ERROR,
    output logic [31:0] oA_RESP_DATA,
    input  logic        iB_CMD_REQ,
    output logic        oB_CMD_BUSY,
    input  logic [3:0]  iB_CMD_COMMAND,
    input  logic [7:0]  iB_CMD_TARGET,
    input  logic [31:0] iB_CMD_DATA,
    output logic        oB_RESP_VALID,
    output logic        oB_RESP_ERROR,
    output logic [31:0] oB_RESP_DATA,
    output logic        oCMD_REQ,
    input  logic        iCMD_BUSY,
    output logic [3:0]  oCMD_COMMAND,
    output logic [7:0]  oCMD_TARGET,
    output logic [31:0] oCMD_DATA,
    input  logic        iRESP_VALID,
    input  logic        iRESP_ERROR,
    input  logic [31:0] iRESP_DATA
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [15:0] LIMIT = 16'(P_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        owner;       // 0 = A, 1 = B
    logic        last_grant;  // 0 = A, 1 = B
    logic [15:0] count;
    logic        a_acc;
    logic        b_acc;
    logic        resp_hit;
    logic        timeout;
    logic        done;
    logic        a_valid;
    logic        b_valid;
    logic        resp_err;
    logic [31:0] resp_data;

    always_comb begin
        oA_CMD_BUSY = (state != S_IDLE) || (iB_CMD_REQ && !last_grant);
        oB_CMD_BUSY = (state != S_IDLE) || (iA_CMD_REQ && last_grant);
        a_acc       = iA_CMD_REQ && !oA_CMD_BUSY;
        b_acc       = iB_CMD_REQ && !oB_CMD_BUSY;
        timeout     = (state != S_IDLE) && (count == LIMIT);
        resp_hit    = (state == S_WAIT) && iRESP_VALID;
        done        = resp_hit || timeout;
        state_nxt   = state;
        unique case (state)
            S_IDLE: begin
                if (a_acc || b_acc)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (timeout)
                    state_nxt = S_IDLE;
                else if (!iCMD_BUSY)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (done)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state        <= S_IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            count        <= '0;
            oCMD_COMMAND <= '0;
            oCMD_TARGET  <= '0;
            oCMD_DATA    <= '0;
            a_valid      <= 1'b0;
            b_valid      <= 1'b0;
            resp_err     <= 1'b0;
            resp_data    <= '0;
        end else begin
            state    <= state_nxt;
            a_valid  <= 1'b0;
            b_valid  <= 1'b0;
            resp_err <= 1'b0;
            resp_data <= '0;
            if (state == S_IDLE) begin
                if (a_acc || b_acc) begin
                    owner        <= b_acc;
                    last_grant   <= b_acc;
                    count        <= '0;
                    oCMD_COMMAND <= b_acc ? iB_CMD_COMMAND : iA_CMD_COMMAND;
                    oCMD_TARGET  <= b_acc ? iB_CMD_TARGET : iA_CMD_TARGET;
                    oCMD_DATA    <= b_acc ? iB_CMD_DATA : iA_CMD_DATA;
                end
            end else if (count != 16'hFFFF) begin
                count <= count + 16'd1;
            end
            // A real response in the timeout cycle takes precedence
            if (done) begin
                a_valid   <= !owner;
                b_valid   <= owner;
                resp_err  <= resp_hit ? iRESP_ERROR : 1'b1;
                resp_data <= resp_hit ? iRESP_DATA : 32'h0;
            end
        end
    end

    assign oCMD_REQ      = (state == S_ISSUE);
    assign oA_RESP_VALID = a_valid;
    assign oA_RESP_ERROR = a_valid && resp_err;
    assign oA_RESP_DATA  = a_valid ? resp_data : 32'h0;
    assign oB_RESP_VALID = b_valid;
    assign oB_RESP_ERROR = b_valid && resp_err;
    assign oB_RESP_DATA  = b_valid ? resp_data : 32'h0;

endmodule
